// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle main controller: opcode values,
// ALUOp encodings, FSM states and the decoded instruction classes.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct7 value that marks an M-extension op inside the R-type opcode
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALUOp encoding consumed by the unchanged ALU control block
  localparam logic [1:0] ALUOP_ADDR   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_M      = 3'd2,
    CLS_I      = 3'd3,
    CLS_LOAD   = 3'd4,
    CLS_STORE  = 3'd5,
    CLS_BRANCH = 3'd6
  } instr_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct7 classifier. Flags anything the core cannot
// execute, including M-ops when the multiplier is configured out.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic [6:0]   opcode,
  input  logic [6:0]   funct7,
  output instr_class_e instr_class,
  output logic         illegal
);

  localparam logic M_EN = (MUL_CYCLES > 0) ? 1'b1 : 1'b0;

  // Map the opcode (and funct7 for R-type) onto an instruction class
  always_comb begin
    instr_class = CLS_NONE;
    illegal     = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_MULDIV) begin
          if (M_EN) begin
            instr_class = CLS_M;
          end else begin
            instr_class = CLS_NONE;
            illegal     = 1'b1;
          end
        end else begin
          instr_class = CLS_R;
        end
      end
      OP_I:      instr_class = CLS_I;
      OP_LOAD:   instr_class = CLS_LOAD;
      OP_STORE:  instr_class = CLS_STORE;
      OP_BRANCH: instr_class = CLS_BRANCH;
      default: begin
        instr_class = CLS_NONE;
        illegal     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I(+M) main controller: sequences FETCH/DECODE/EXEC/MEM/WB,
// handshakes with instruction and data memory and stalls EXEC for the
// multiplier. Outputs follow the state and the opcode latched in DECODE.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int ALUOP_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [6:0]         funct7,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic               dmem_req,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               branch,
  output logic               mul_busy,
  output logic               reg_write,
  output logic               wb_sel,
  output logic               illegal_instr,
  output logic               retire
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 2);
  localparam logic [CNT_W-1:0] MUL_LOAD =
    (MUL_CYCLES > 0) ? CNT_W'(MUL_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_r;
  state_e           state_s;
  logic [6:0]       opcode_r;
  logic [6:0]       funct7_r;
  logic [CNT_W-1:0] mul_cnt_r;
  logic [CNT_W-1:0] mul_cnt_s;
  logic [6:0]       dec_opcode_s;
  logic [6:0]       dec_funct7_s;
  instr_class_e     cls_s;
  logic             dec_illegal_s;
  logic [1:0]       aluop_s;

  // Decode the live instruction in DECODE, the latched one everywhere else
  always_comb begin
    if (state_r == DECODE) begin
      dec_opcode_s = opcode;
      dec_funct7_s = funct7;
    end else begin
      dec_opcode_s = opcode_r;
      dec_funct7_s = funct7_r;
    end
  end

  ctrl_decode #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_decode (
    .opcode      (dec_opcode_s),
    .funct7      (dec_funct7_s),
    .instr_class (cls_s),
    .illegal     (dec_illegal_s)
  );

  // State, latched instruction fields and multiplier countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= FETCH;
      opcode_r  <= 7'd0;
      funct7_r  <= 7'd0;
      mul_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      mul_cnt_r <= mul_cnt_s;
      if (state_r == DECODE) begin
        opcode_r <= opcode;
        funct7_r <= funct7;
      end else begin
        opcode_r <= opcode_r;
        funct7_r <= funct7_r;
      end
    end
  end

  // Next state and control outputs; everything is forced low while in reset
  always_comb begin
    state_s       = state_r;
    mul_cnt_s     = mul_cnt_r;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    dmem_req      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    aluop_s       = ALUOP_ADDR;
    branch        = 1'b0;
    mul_busy      = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 1'b0;
    illegal_instr = 1'b0;
    retire        = 1'b0;
    if (rst) begin
      state_s   = FETCH;
      mul_cnt_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_s  = DECODE;
          end else begin
            state_s  = FETCH;
          end
        end
        DECODE: begin
          if (dec_illegal_s) begin
            illegal_instr = 1'b1;
            state_s       = FETCH;
          end else begin
            state_s = EXEC;
            if (cls_s == CLS_M) begin
              mul_cnt_s = MUL_LOAD;
            end else begin
              mul_cnt_s = {CNT_W{1'b0}};
            end
          end
        end
        EXEC: begin
          case (cls_s)
            CLS_R: begin
              aluop_s = ALUOP_RTYPE;
              state_s = WB;
            end
            CLS_M: begin
              aluop_s  = ALUOP_RTYPE;
              mul_busy = 1'b1;
              if (mul_cnt_r == {CNT_W{1'b0}}) begin
                state_s = WB;
              end else begin
                mul_cnt_s = mul_cnt_r - CNT_ONE;
                state_s   = EXEC;
              end
            end
            CLS_I: begin
              aluop_s = ALUOP_ITYPE;
              state_s = WB;
            end
            CLS_LOAD, CLS_STORE: begin
              aluop_s = ALUOP_ADDR;
              state_s = MEM;
            end
            CLS_BRANCH: begin
              aluop_s = ALUOP_BRANCH;
              branch  = 1'b1;
              retire  = 1'b1;
              state_s = FETCH;
            end
            default: state_s = FETCH;
          endcase
        end
        MEM: begin
          dmem_req  = 1'b1;
          mem_read  = (cls_s == CLS_LOAD);
          mem_write = (cls_s == CLS_STORE);
          if (dmem_ready) begin
            if (cls_s == CLS_LOAD) begin
              state_s = WB;
            end else begin
              retire  = 1'b1;
              state_s = FETCH;
            end
          end else begin
            state_s = MEM;
          end
        end
        WB: begin
          reg_write = 1'b1;
          wb_sel    = (cls_s == CLS_LOAD);
          retire    = 1'b1;
          state_s   = FETCH;
        end
        default: state_s = FETCH;
      endcase
    end
  end

  assign ALUOp = ALUOP_W'(aluop_s);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit. Stimulus pushes the expected
// output vector for every cycle; a monitor on the falling edge pops and
// compares. A second instance built with MUL_CYCLES=0 covers the no-M build.
module tb_multicycle_control_unit;

  // Output vector layout: {imem_req, ir_write, pc_write, dmem_req, mem_read,
  // mem_write, ALUOp[1:0], branch, mul_busy, reg_write, wb_sel,
  // illegal_instr, retire}
  localparam logic [13:0] NONE = 14'h0000;
  localparam logic [13:0] REQ  = 14'h2000;
  localparam logic [13:0] IRW  = 14'h1000;
  localparam logic [13:0] PCW  = 14'h0800;
  localparam logic [13:0] DREQ = 14'h0400;
  localparam logic [13:0] MRD  = 14'h0200;
  localparam logic [13:0] MWR  = 14'h0100;
  localparam logic [13:0] A_R  = 14'h0080;
  localparam logic [13:0] A_I  = 14'h00C0;
  localparam logic [13:0] A_B  = 14'h0040;
  localparam logic [13:0] BR   = 14'h0020;
  localparam logic [13:0] MB   = 14'h0010;
  localparam logic [13:0] RW   = 14'h0008;
  localparam logic [13:0] WS   = 14'h0004;
  localparam logic [13:0] ILL  = 14'h0002;
  localparam logic [13:0] RET  = 14'h0001;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_BAD = 7'b1111111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst0;
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       imem_ready;
  logic       dmem_ready;

  logic       imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write;
  logic [1:0] alu_op;
  logic       branch, mul_busy, reg_write, wb_sel, illegal_instr, retire;

  logic       imem_req0, ir_write0, pc_write0, dmem_req0, mem_read0, mem_write0;
  logic [1:0] alu_op0;
  logic       branch0, mul_busy0, reg_write0, wb_sel0, illegal_instr0, retire0;

  logic [13:0] act;
  logic [13:0] act0;

  logic [13:0] q[$];
  logic [13:0] q0[$];
  logic        sel0;
  string       tname;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MUL_CYCLES(4), .ALUOP_W(2)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .dmem_req(dmem_req), .mem_read(mem_read), .mem_write(mem_write),
    .ALUOp(alu_op), .branch(branch), .mul_busy(mul_busy),
    .reg_write(reg_write), .wb_sel(wb_sel),
    .illegal_instr(illegal_instr), .retire(retire)
  );

  multicycle_control_unit #(.MUL_CYCLES(0), .ALUOP_W(2)) dut0 (
    .clk(clk), .rst(rst0), .opcode(opcode), .funct7(funct7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req0), .ir_write(ir_write0), .pc_write(pc_write0),
    .dmem_req(dmem_req0), .mem_read(mem_read0), .mem_write(mem_write0),
    .ALUOp(alu_op0), .branch(branch0), .mul_busy(mul_busy0),
    .reg_write(reg_write0), .wb_sel(wb_sel0),
    .illegal_instr(illegal_instr0), .retire(retire0)
  );

  assign act  = {imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write,
                 alu_op, branch, mul_busy, reg_write, wb_sel, illegal_instr, retire};
  assign act0 = {imem_req0, ir_write0, pc_write0, dmem_req0, mem_read0, mem_write0,
                 alu_op0, branch0, mul_busy0, reg_write0, wb_sel0, illegal_instr0, retire0};

  // Monitor: compare both instances against their expected vectors
  always @(negedge clk) begin
    logic [13:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s dut t=%0t got=%b exp=%b", tname, $time, act, e);
      end
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      tests++;
      if (act0 !== e) begin
        fails++;
        $display("FAIL %s dut0 t=%0t got=%b exp=%b", tname, $time, act0, e);
      end
    end
  end

  // One clock cycle: queue what the selected instance should show, the other idles
  task automatic cyc(input logic [13:0] e);
    if (sel0) begin
      q.push_back(NONE);
      q0.push_back(e);
    end else begin
      q.push_back(e);
      q0.push_back(NONE);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      dmem_ready = 1'b1;
      cyc(REQ);
    end
    imem_ready = 1'b1;
    cyc(REQ | IRW | PCW);
  endtask

  // Opcode is valid only in DECODE; scramble it afterwards
  task automatic decode(input logic [6:0] op, input logic [6:0] f7, input logic [13:0] e);
    opcode     = op;
    funct7     = f7;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    cyc(e);
    opcode = OPC_BAD;
    funct7 = 7'b0101010;
  endtask

  initial begin
    rst        = 1'b1;
    rst0       = 1'b1;
    sel0       = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    opcode     = OPC_R;
    funct7     = 7'd0;
    tname      = "reset";
    @(posedge clk);
    #1;
    repeat (3) cyc(NONE);
    rst = 1'b0;

    tname = "rtype_add";
    fetch(0); decode(OPC_R, 7'd0, NONE); cyc(A_R); cyc(RW | RET);

    tname = "itype_imem_wait";
    fetch(2); decode(OPC_I, 7'b0100000, NONE); cyc(A_I); cyc(RW | RET);

    tname = "load_dmem_wait3";
    fetch(0); decode(OPC_LD, 7'd0, NONE); cyc(NONE);
    dmem_ready = 1'b0;
    repeat (3) cyc(DREQ | MRD);
    dmem_ready = 1'b1;
    cyc(DREQ | MRD);
    cyc(RW | WS | RET);

    tname = "mul_4cyc";
    fetch(0); decode(OPC_R, 7'b0000001, NONE);
    repeat (4) cyc(A_R | MB);
    cyc(RW | RET);

    tname = "illegal_ff";
    fetch(0); decode(OPC_BAD, 7'd0, ILL);
    tname = "illegal_jal";
    fetch(0); decode(OPC_JAL, 7'd0, ILL);

    tname = "store";
    fetch(0); decode(OPC_ST, 7'd0, NONE); cyc(NONE);
    cyc(DREQ | MWR | RET);
    tname = "branch";
    fetch(0); decode(OPC_BR, 7'd0, NONE); cyc(A_B | BR | RET);

    tname = "rst_mid_mem";
    fetch(0); decode(OPC_LD, 7'd0, NONE); cyc(NONE);
    dmem_ready = 1'b0;
    cyc(DREQ | MRD);
    rst = 1'b1;
    cyc(NONE);
    rst = 1'b0;
    dmem_ready = 1'b1;
    fetch(0); decode(OPC_R, 7'd0, NONE); cyc(A_R); cyc(RW | RET);

    tname = "rst_mid_mul";
    fetch(0); decode(OPC_R, 7'b0000001, NONE);
    repeat (2) cyc(A_R | MB);
    rst = 1'b1;
    cyc(NONE);
    rst = 1'b0;
    fetch(0); decode(OPC_R, 7'b0000001, NONE);
    repeat (4) cyc(A_R | MB);
    cyc(RW | RET);

    tname = "no_m_build";
    rst  = 1'b1;
    rst0 = 1'b0;
    sel0 = 1'b1;
    fetch(0); decode(OPC_R, 7'b0000001, ILL);
    fetch(0); decode(OPC_R, 7'd0, NONE); cyc(A_R); cyc(RW | RET);
    rst0 = 1'b1;
    cyc(NONE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
